// File: rtl/ldpc_pkg.sv
// Shared constants and state encoding for the LDPC decoder input/output byte stages.
package ldpc_pkg;

  localparam int FRAME_W = 9216;
  localparam int BYTE_W  = 8;
  localparam int NBYTES  = FRAME_W / BYTE_W;
  localparam int CNT_W   = 11;

  typedef enum logic {
    S_FILL = 1'b0,
    S_FULL = 1'b1
  } din_state_t;

endpackage

// File: rtl/data_in_if.sv
// Byte-stream and frame handshake bundle between the channel source, data_in and the decoder.
interface data_in_if
  import ldpc_pkg::*;
();

  logic [BYTE_W-1:0]  d_in;
  logic               en_in;
  logic               rdy_in;
  logic               clr_in;
  logic               load_vin;
  logic [FRAME_W-1:0] v_in;
  logic               frame_vld;
  logic               rst_flag;
  logic               ovr_flag;

  modport master (
    output d_in, en_in, clr_in, load_vin, rst_flag,
    input  rdy_in, v_in, frame_vld, ovr_flag
  );

  modport slave (
    input  d_in, en_in, clr_in, load_vin, rst_flag,
    output rdy_in, v_in, frame_vld, ovr_flag
  );

endinterface

// File: rtl/data_in_din_ctrl.sv
// Fill/full FSM, byte counter and sticky overrun flag for the input deserializer.
// Overrun logic is present only when DIN_OVERRUN_EN is defined.
module din_ctrl
  import ldpc_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en_in,
  input  logic clr_in,
  input  logic load_vin,
`ifdef DIN_OVERRUN_EN
  input  logic rst_flag,
`endif
  output logic rdy_in,
  output logic frame_vld,
  output logic ovr_flag,
  output logic shift_en
);

  din_state_t       state, state_nxt;
  logic [CNT_W-1:0] count_in, count_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FILL;
      count_in <= '0;
    end else begin
      state    <= state_nxt;
      count_in <= count_nxt;
    end
  end

  // Abort wins over everything; a dropped transfer under clr_in never shifts.
  always_comb begin
    state_nxt = state;
    count_nxt = count_in;
    shift_en  = 1'b0;
    if (clr_in) begin
      state_nxt = S_FILL;
      count_nxt = '0;
    end else begin
      case (state)
        S_FILL: begin
          if (en_in) begin
            shift_en = 1'b1;
            if (count_in == CNT_W'(NBYTES - 1)) begin
              count_nxt = '0;
              state_nxt = S_FULL;
            end else begin
              count_nxt = count_in + 1'b1;
            end
          end
        end
        S_FULL: begin
          if (load_vin) state_nxt = S_FILL;
        end
        default: state_nxt = S_FILL;
      endcase
    end
  end

  assign rdy_in    = (state == S_FILL);
  assign frame_vld = (state == S_FULL);

`ifdef DIN_OVERRUN_EN
  // Clear has priority over a same-cycle overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_flag <= 1'b0;
    end else if (!rst_flag) begin
      ovr_flag <= 1'b0;
    end else if (en_in && !rdy_in) begin
      ovr_flag <= 1'b1;
    end
  end
`else
  assign ovr_flag = 1'b0;
`endif

endmodule

// File: rtl/data_in.sv
// Input deserializer: packs channel bytes into a FRAME_W-bit codeword for the NMS LDPC decoder.
// Optional sticky overrun flag enabled by defining DIN_OVERRUN_EN.
module data_in
  import ldpc_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  data_in_if.slave  bus
);

  logic               shift_en;
  logic [FRAME_W-1:0] vin;

  din_ctrl u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_in     (bus.en_in),
    .clr_in    (bus.clr_in),
    .load_vin  (bus.load_vin),
`ifdef DIN_OVERRUN_EN
    .rst_flag  (bus.rst_flag),
`endif
    .rdy_in    (bus.rdy_in),
    .frame_vld (bus.frame_vld),
    .ovr_flag  (bus.ovr_flag),
    .shift_en  (shift_en)
  );

  // Bytes enter at the top and walk down, so the first byte ends at [BYTE_W-1:0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vin <= '0;
    end else if (shift_en) begin
      vin <= {bus.d_in, vin[FRAME_W-1:BYTE_W]};
    end
  end

  assign bus.v_in = vin;

endmodule

// File: tb/tb_data_in.sv
// Directed self-checking bench for the data_in input deserializer.
module tb_data_in;
  import ldpc_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  logic [FRAME_W-1:0] exp_v;
  logic [FRAME_W-1:0] saved_v;

  data_in_if bus ();

  data_in dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    bus.en_in = 1'b1;
    bus.d_in  = b;
    tick();
    bus.en_in = 1'b0;
  endtask

  task automatic load_frame();
    bus.load_vin = 1'b1;
    tick();
    bus.load_vin = 1'b0;
  endtask

  initial begin
    int xfers;
    int cycles;
    int early;
    logic [7:0] b;

    n_cmp = 0;
    n_bad = 0;
    bus.d_in     = '0;
    bus.en_in    = 1'b0;
    bus.clr_in   = 1'b0;
    bus.load_vin = 1'b0;
    bus.rst_flag = 1'b1;
    rst_n        = 1'b0;
    exp_v        = '0;

    // 1: reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdy", 32'(bus.rdy_in), 32'd1);
    check("rst_vld", 32'(bus.frame_vld), 32'd0);
    check("rst_ovr", 32'(bus.ovr_flag), 32'd0);
    check("rst_vin_zero", 32'(bus.v_in == '0), 32'd1);
    rst_n = 1'b1;
    tick();

    // 2: back-to-back 0x00..0x7F repeating
    for (int i = 0; i < NBYTES; i++) begin
      if (i == NBYTES - 1) check("f1_vld_before_last", 32'(bus.frame_vld), 32'd0);
      push(8'(i % 128));
    end
    check("f1_vld", 32'(bus.frame_vld), 32'd1);
    check("f1_rdy", 32'(bus.rdy_in), 32'd0);
    check("f1_byte0", 32'(bus.v_in[7:0]), 32'h00);
    check("f1_byte1", 32'(bus.v_in[15:8]), 32'h01);
    check("f1_last", 32'(bus.v_in[FRAME_W-1 -: 8]), 32'h7F);

    // 3: hold under incoming bytes, overrun flag, flag clear
    saved_v = bus.v_in;
    bus.en_in = 1'b1;
    bus.d_in  = 8'hAA;
    repeat (20) tick();
    bus.en_in = 1'b0;
    check("hold_vin", 32'(bus.v_in == saved_v), 32'd1);
    check("hold_vld", 32'(bus.frame_vld), 32'd1);
`ifdef DIN_OVERRUN_EN
    check("ovr_set", 32'(bus.ovr_flag), 32'd1);
`else
    check("ovr_set", 32'(bus.ovr_flag), 32'd0);
`endif
    bus.rst_flag = 1'b0;
    tick();
    bus.rst_flag = 1'b1;
    check("ovr_clr", 32'(bus.ovr_flag), 32'd0);

    // 4: load handshake, second frame from count 0
    bus.load_vin = 1'b1;
    check("load_cycle_vld", 32'(bus.frame_vld), 32'd1);
    tick();
    bus.load_vin = 1'b0;
    check("post_load_vld", 32'(bus.frame_vld), 32'd0);
    check("post_load_rdy", 32'(bus.rdy_in), 32'd1);
    check("post_load_vin_kept", 32'(bus.v_in == saved_v), 32'd1);
    for (int i = 0; i < NBYTES; i++) begin
      b = 8'((i * 3 + 5) & 8'hFF);
      exp_v[8*i +: 8] = b;
      if (i == NBYTES - 1) check("f2_vld_before_last", 32'(bus.frame_vld), 32'd0);
      push(b);
    end
    check("f2_vld", 32'(bus.frame_vld), 32'd1);
    check("f2_vin", 32'(bus.v_in == exp_v), 32'd1);
    check("f2_last", 32'(bus.v_in[FRAME_W-1 -: 8]), 32'(((NBYTES - 1) * 3 + 5) & 8'hFF));
    load_frame();

    // 5: gapped input, stray load_vin pulses during fill are ignored
    xfers  = 0;
    cycles = 0;
    early  = 0;
    while (xfers < NBYTES && cycles < 6000) begin
      b = 8'(xfers ^ 8'h5A);
      bus.d_in     = b;
      bus.en_in    = 1'($urandom_range(0, 1));
      bus.load_vin = ($urandom_range(0, 15) == 0);
      if (bus.en_in) exp_v[8*xfers +: 8] = b;
      tick();
      if (bus.en_in) xfers++;
      cycles++;
      if (xfers < NBYTES && bus.frame_vld) early++;
    end
    bus.en_in    = 1'b0;
    bus.load_vin = 1'b0;
    check("gap_xfers_done", 32'(xfers), 32'(NBYTES));
    check("gap_no_early_vld", 32'(early), 32'd0);
    check("gap_vld", 32'(bus.frame_vld), 32'd1);
    check("gap_vin", 32'(bus.v_in == exp_v), 32'd1);
    load_frame();

    // 6: partial frame aborted by clr_in; the byte offered with clr_in is dropped
    for (int i = 0; i < 500; i++) push(8'hEE);
    bus.clr_in = 1'b1;
    push(8'h11);
    bus.clr_in = 1'b0;
    check("clr_rdy", 32'(bus.rdy_in), 32'd1);
    for (int i = 0; i < NBYTES; i++) begin
      b = 8'((i + 8'h33) & 8'hFF);
      exp_v[8*i +: 8] = b;
      if (i == NBYTES - 1) check("clr_vld_before_last", 32'(bus.frame_vld), 32'd0);
      push(b);
    end
    check("clr_vld", 32'(bus.frame_vld), 32'd1);
    check("clr_byte0", 32'(bus.v_in[7:0]), 32'h33);
    check("clr_vin", 32'(bus.v_in == exp_v), 32'd1);

    // clr_in in the full state beats a simultaneous load and empties the frame slot
    bus.clr_in   = 1'b1;
    bus.load_vin = 1'b1;
    tick();
    bus.clr_in   = 1'b0;
    bus.load_vin = 1'b0;
    check("clr_full_vld", 32'(bus.frame_vld), 32'd0);
    check("clr_full_vin_kept", 32'(bus.v_in == exp_v), 32'd1);

    // Asynchronous reset mid-frame
    for (int i = 0; i < 10; i++) push(8'hC3);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_vin", 32'(bus.v_in == '0), 32'd1);
    check("async_rst_rdy", 32'(bus.rdy_in), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < NBYTES - 1; i++) push(8'h01);
    check("rst_restart_not_full", 32'(bus.frame_vld), 32'd0);
    push(8'h02);
    check("rst_restart_full", 32'(bus.frame_vld), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
